alert_uart_tx: RTL and testbench



---
 rtl/fire_link_pkg.sv | 37 +++
 rtl/uart_tx_core.sv | 105 ++++++++++
 rtl/alert_uart_tx.sv | 112 +++++++++++
 tb/tb_alert_uart_tx.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fire_link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fire_link_pkg
// Description : Shared definitions for the FPGA-to-ESP32 alert UART link:
//               frame field positions, status bit indices, transmitter
//               state encoding and the frame parity helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fire_link_pkg;

    // Frame byte layout
    localparam int STATUS_LSB = 0;
    localparam int SEQ_LSB    = 3;
    localparam int PAR_BIT    = 7;
    localparam int STATUS_W   = 3;
    localparam int SEQ_W      = 4;

    // Status vector bit indices: {cam, fft, alert}
    localparam int ALERT_BIT  = 0;
    localparam int FFT_BIT    = 1;
    localparam int CAM_BIT    = 2;

    // Transmitter state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // Parity bit that makes the total count of ones in the byte odd
    function automatic logic odd_parity(input logic [6:0] bits);
        return ~(^bits);
    endfunction

endpackage : fire_link_pkg
`default_nettype wire

// File: rtl/uart_tx_core.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_core
// Description : 8N1 UART serializer. Latches a byte on start while idle and
//               shifts it out LSB first with one start and one stop bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_core
    import fire_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int                 c_CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_PRE  = c_CNT_W'(CLKS_PER_BIT - 2);

    tx_state_t          r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_tx;
    logic               r_busy;
    logic               r_done;

    // Frame sequencer: bit-period timing, bit counting, shifting and registered line outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    r_done <= 1'b0;
                    r_cnt  <= '0;
                    if (start) begin
                        r_shift <= data;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (r_cnt == c_CNT_LAST) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (r_cnt == c_CNT_LAST) begin
                        r_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    // done is registered so it is high during the final stop-bit cycle
                    r_done <= (r_cnt == c_CNT_PRE);
                    if (r_cnt == c_CNT_LAST) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign tx   = r_tx;
    assign busy = r_busy;
    assign done = r_done;

endmodule : uart_tx_core
`default_nettype wire

// File: rtl/alert_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : alert_uart_tx
// Description : Sends fused fire-alert status {cam, fft, alert} to the ESP32
//               as 8N1 frames on every status change and as a periodic
//               heartbeat. Frame = {odd parity, seq[3:0], status[2:0]}.
// Revision    : 1.0 - initial release
// ============================================================================
module alert_uart_tx
    import fire_link_pkg::*;
#(
    parameter int CLK_FREQ_HZ      = 50_000_000,
    parameter int BAUD             = 115_200,
    parameter int HEARTBEAT_CYCLES = 50_000_000,
    parameter int SYNC_STAGES      = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic alert_in,
    input  logic fft_in,
    input  logic cam_in,
    output logic tx,
    output logic busy,
    output logic frame_done
);

    localparam int                c_CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int                c_HB_W         = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;
    localparam logic [c_HB_W-1:0] c_HB_LAST      = c_HB_W'(HEARTBEAT_CYCLES - 1);

    if (c_CLKS_PER_BIT < 4) begin : g_baud_check
        $error("alert_uart_tx: CLK_FREQ_HZ/BAUD must be at least 4");
    end

    logic [STATUS_W-1:0] w_status_raw;
    logic [STATUS_W-1:0] r_sync [SYNC_STAGES];
    logic [STATUS_W-1:0] w_status_sync;
    logic [STATUS_W-1:0] r_last_sent;
    logic [SEQ_W-1:0]    r_seq;
    logic [c_HB_W-1:0]   r_hb_cnt;
    logic                w_core_busy;
    logic                w_idle;
    logic                w_pending;
    logic                w_launch;
    logic [7:0]          w_frame;

    assign w_status_raw[ALERT_BIT] = alert_in;
    assign w_status_raw[FFT_BIT]   = fft_in;
    assign w_status_raw[CAM_BIT]   = cam_in;

    // Multi-flop synchronizer chain on all three status lines
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= w_status_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_status_sync = r_sync[SYNC_STAGES-1];

    // The core's busy flag is low exactly while its FSM sits in IDLE
    assign w_idle    = ~w_core_busy;
    assign w_pending = (w_status_sync != r_last_sent) || (r_hb_cnt == c_HB_LAST);
    assign w_launch  = w_idle & w_pending;

    // Frame assembly from the live synchronized status and current sequence number
    always_comb begin
        w_frame                             = '0;
        w_frame[STATUS_LSB +: STATUS_W]     = w_status_sync;
        w_frame[SEQ_LSB +: SEQ_W]           = r_seq;
        w_frame[PAR_BIT]                    = odd_parity({r_seq, w_status_sync});
    end

    // Launch bookkeeping: last-sent snapshot, sequence number and heartbeat timer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_sent <= '0;
            r_seq       <= '0;
            r_hb_cnt    <= '0;
        end else if (w_launch) begin
            r_last_sent <= w_status_sync;
            r_seq       <= r_seq + SEQ_W'(1);
            r_hb_cnt    <= '0;
        end else if (w_idle) begin
            r_hb_cnt    <= r_hb_cnt + c_HB_W'(1);
        end else begin
            r_hb_cnt    <= '0;
        end
    end

    uart_tx_core #(
        .CLKS_PER_BIT (c_CLKS_PER_BIT)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .start (w_launch),
        .data  (w_frame),
        .tx    (tx),
        .busy  (w_core_busy),
        .done  (frame_done)
    );

    assign busy = w_core_busy;

endmodule : alert_uart_tx
`default_nettype wire

// File: tb/tb_alert_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_alert_uart_tx
// Description : Self-checking bench for alert_uart_tx at 10 clocks per bit
//               and a 500-cycle heartbeat. A line monitor decodes frames
//               and compares them against a queue of expected bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alert_uart_tx;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic alert_in = 1'b0;
    logic fft_in = 1'b0;
    logic cam_in = 1'b0;
    logic tx;
    logic busy;
    logic frame_done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] sb [$];

    typedef struct {
        logic       alert;
        logic       fft;
        logic       cam;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t tbl [8];

    alert_uart_tx #(
        .CLK_FREQ_HZ      (1000),
        .BAUD             (100),
        .HEARTBEAT_CYCLES (500),
        .SYNC_STAGES      (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .alert_in   (alert_in),
        .fft_in     (fft_in),
        .cam_in     (cam_in),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference frame byte: {odd parity, seq, status}
    function automatic logic [7:0] model_byte(input logic [2:0] st, input logic [3:0] sq);
        logic [6:0] low;
        low = {sq, st};
        return {~(^low), low};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        alert_in = 1'b0;
        fft_in = 1'b0;
        cam_in = 1'b0;
        sb.delete();
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        reset = 1'b0;
    endtask

    task automatic wait_done(input int max, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic wait_busy(input int max, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic expect_quiet(input int n, input string name);
        bit all_high;
        all_high = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) all_high = 1'b0;
        end
        check(name, 32'(all_high), 32'd1);
    endtask

    // Line monitor: decodes frames mid-bit, checks framing, parity, busy width and done timing
    initial begin
        bit         mon_active;
        bit         fall_ok;
        int         mon_cnt;
        int         fall_cyc;
        int         busy_run;
        logic [7:0] mon_byte;
        logic [7:0] exp_b;
        mon_active = 1'b0;
        fall_ok    = 1'b0;
        mon_cnt    = 0;
        fall_cyc   = 0;
        busy_run   = 0;
        mon_byte   = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_active = 1'b0;
                fall_ok    = 1'b0;
                busy_run   = 0;
            end else begin
                if (busy) begin
                    busy_run++;
                end else if (busy_run != 0) begin
                    check("busy_len", 32'(busy_run), 32'd100);
                    busy_run = 0;
                end
                if (frame_done) begin
                    check("done_pos", fall_ok ? 32'(cyc - fall_cyc) : 32'hFFFF_FFFF, 32'd99);
                    fall_ok = 1'b0;
                end
                if (!mon_active) begin
                    if (tx === 1'b0) begin
                        mon_active = 1'b1;
                        mon_cnt    = 0;
                        fall_cyc   = cyc;
                        fall_ok    = 1'b1;
                    end
                end else begin
                    mon_cnt++;
                    if (mon_cnt == 5) check("start_bit", 32'(tx), 32'd0);
                    if (mon_cnt >= 15 && mon_cnt <= 85 && ((mon_cnt - 15) % 10) == 0)
                        mon_byte[(mon_cnt - 15) / 10] = tx;
                    if (mon_cnt == 95) begin
                        check("stop_bit", 32'(tx), 32'd1);
                        check("parity", 32'(^mon_byte), 32'd1);
                        check("frame_expected", 32'(sb.size() != 0), 32'd1);
                        if (sb.size() != 0) begin
                            exp_b = sb.pop_front();
                            check("frame_byte", 32'(mon_byte), 32'(exp_b));
                        end
                        mon_active = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit all_high;

        // Status patterns after a fresh reset, in order: seq advances 0..7
        tbl[0] = '{alert: 1'b1, fft: 1'b0, cam: 1'b0, exp_byte: 8'h01};
        tbl[1] = '{alert: 1'b0, fft: 1'b1, cam: 1'b0, exp_byte: 8'h8A};
        tbl[2] = '{alert: 1'b0, fft: 1'b0, cam: 1'b1, exp_byte: 8'h94};
        tbl[3] = '{alert: 1'b1, fft: 1'b1, cam: 1'b1, exp_byte: 8'h1F};
        tbl[4] = '{alert: 1'b0, fft: 1'b0, cam: 1'b0, exp_byte: 8'h20};
        tbl[5] = '{alert: 1'b1, fft: 1'b0, cam: 1'b1, exp_byte: 8'hAD};
        tbl[6] = '{alert: 1'b0, fft: 1'b1, cam: 1'b1, exp_byte: 8'hB6};
        tbl[7] = '{alert: 1'b1, fft: 1'b1, cam: 1'b0, exp_byte: 8'h3B};

        // First heartbeat after reset with all inputs low
        do_reset();
        sb.push_back(8'h80);
        all_high = 1'b1;
        for (int j = 1; j <= 499; j++) begin
            @(negedge clk);
            if (tx !== 1'b1) all_high = 1'b0;
        end
        check("hb_idle_high", 32'(all_high), 32'd1);
        @(negedge clk);
        check("hb_fall", 32'(tx), 32'd0);
        wait_done(120, "hb_first_done");

        // Change latency and back-to-back frame on a mid-frame change
        do_reset();
        repeat (10) @(negedge clk);
        alert_in = 1'b1;
        fft_in   = 1'b1;
        sb.push_back(8'h83);
        @(negedge clk);
        @(negedge clk);
        check("lat_pre", 32'(tx), 32'd1);
        check("lat_busy_pre", 32'(busy), 32'd0);
        @(negedge clk);
        check("lat_fall", 32'(tx), 32'd0);
        check("lat_busy", 32'(busy), 32'd1);
        repeat (30) @(negedge clk);
        cam_in = 1'b1;
        sb.push_back(8'h8F);
        wait_done(100, "f1_done");
        @(negedge clk);
        check("gap_busy", 32'(busy), 32'd0);
        check("gap_tx", 32'(tx), 32'd1);
        @(negedge clk);
        check("b2b_tx", 32'(tx), 32'd0);
        check("b2b_busy", 32'(busy), 32'd1);
        wait_done(120, "f2_done");

        // Seventeen heartbeats: seq wraps 15 -> 0, no extra frames
        do_reset();
        for (int k = 0; k < 17; k++) sb.push_back(model_byte(3'b000, 4'(k)));
        for (int k = 0; k < 17; k++) wait_done(700, "hb_run_done");
        expect_quiet(300, "hb_no_extra");
        check("hb_sb_empty", 32'(sb.size()), 32'd0);

        // One-cycle fft glitch during a frame returns to last_sent: no frame
        sb.push_back(model_byte(3'b000, 4'd1));
        wait_busy(400, "hb_next_start");
        repeat (20) @(negedge clk);
        fft_in = 1'b1;
        @(negedge clk);
        fft_in = 1'b0;
        wait_done(120, "glitch_frame_done");
        expect_quiet(50, "glitch_no_frame");

        // Five-cycle fft pulse while idle: one frame with fft=1, one back to 0
        fft_in = 1'b1;
        sb.push_back(model_byte(3'b010, 4'd2));
        sb.push_back(model_byte(3'b000, 4'd3));
        repeat (5) @(negedge clk);
        fft_in = 1'b0;
        wait_done(120, "pulse_a_done");
        wait_done(150, "pulse_b_done");

        // Table of status patterns from a fresh reset
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            alert_in = tbl[i].alert;
            fft_in   = tbl[i].fft;
            cam_in   = tbl[i].cam;
            sb.push_back(tbl[i].exp_byte);
            wait_done(150, "tbl_done");
        end

        // Reset in the middle of data bit 4, then frame restarts at seq 0
        @(negedge clk);
        fft_in = 1'b0;
        wait_busy(20, "abort_start");
        repeat (55) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        check("abort_tx", 32'(tx), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(frame_done), 32'd0);
        all_high = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            if (frame_done !== 1'b0) all_high = 1'b0;
        end
        reset = 1'b0;
        sb.push_back(8'h01);
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (frame_done !== 1'b0) all_high = 1'b0;
        end
        check("abort_no_done", 32'(all_high), 32'd1);
        wait_done(120, "restart_done");

        repeat (5) @(negedge clk);
        check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_alert_uart_tx
`default_nettype wire
